demux_1x4_tdm: RTL and testbench

DEMUX_1X4_TDM -- requirements
Module: demux_1x4_tdm

---
 rtl/demux_1x4_tdm.sv | 126 ++++++++++++
 tb/tb_demux_1x4_tdm.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_tdm.sv
// 1-to-4 TDM demultiplexer: collects four strobed serial slots into a parallel
// frame and tracks alignment through HUNT -> ACQ -> LOCKED.
module demux_1x4_tdm #(
  parameter int unsigned LOCK_CNT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Y,
  input  logic       EN,
  input  logic       SYNC,
  input  logic       CLR,
  output logic [3:0] O,
  output logic [1:0] S,
  output logic       VALID,
  output logic       LOCK,
  output logic       ERR
);

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_e;

  localparam logic [4:0] LockCnt = 5'(LOCK_CNT);

  state_e     state_q, state_d;
  logic [1:0] slot_q, slot_d;
  logic [2:0] buf_q, buf_d;
  logic [3:0] o_q, o_d;
  logic [3:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic       err_det;

  // NOTE: every variable gets its hold value first so no path leaves one
  // unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    buf_d   = buf_q;
    o_d     = o_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    lock_d  = lock_q;
    err_det = 1'b0;

    if (EN) begin
      unique case (state_q)
        HUNT: begin
          if (SYNC) begin
            buf_d[0] = Y;
            slot_d   = 2'd1;
            state_d  = ACQ;
          end
        end
        default: begin
          if (SYNC) begin
            // A marker mid-frame restarts the frame from this beat.
            if (slot_q != 2'd0) begin
              err_det = 1'b1;
              lock_d  = 1'b0;
              cnt_d   = 4'd0;
              state_d = ACQ;
            end
            buf_d[0] = Y;
            slot_d   = 2'd1;
          end else if (slot_q == 2'd0) begin
            err_det = 1'b1;
            lock_d  = 1'b0;
            cnt_d   = 4'd0;
            state_d = HUNT;
          end else if (slot_q == 2'd3) begin
            o_d     = {Y, buf_q};
            valid_d = 1'b1;
            slot_d  = 2'd0;
            if ({1'b0, cnt_q} < LockCnt) cnt_d = cnt_q + 4'd1;
            if (({1'b0, cnt_q} + 5'd1) >= LockCnt) begin
              state_d = LOCKED;
              lock_d  = 1'b1;
            end
          end else begin
            unique case (slot_q)
              2'd1:    buf_d[1] = Y;
              default: buf_d[2] = Y;
            endcase
            slot_d = slot_q + 2'd1;
          end
        end
      endcase
    end

    // A fresh error wins over a simultaneous clear.
    err_d = err_det | (err_q & ~CLR);
  end

  // NOTE: state uses non-blocking assignments so all registers update
  // together from the values seen before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the slot buffer is reset too, since it is small and a clean
      // known value keeps the first frames deterministic.
      state_q <= HUNT;
      slot_q  <= 2'd0;
      buf_q   <= 3'd0;
      o_q     <= 4'd0;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  assign O     = o_q;
  assign S     = slot_q;
  assign VALID = valid_q;
  assign LOCK  = lock_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Testbench for demux_1x4_tdm: directed frame scenarios followed by random
// beats, all compared against a queue-based frame model.
module tb_demux_1x4_tdm;

  localparam int LC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Y = 1'b0, EN = 1'b0, SYNC = 1'b0, CLR = 1'b0;
  logic [3:0] O;
  logic [1:0] S;
  logic       VALID, LOCK, ERR;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: partial frame as a bit queue, count of good frames.
  bit       frame_q[$];
  bit       m_hunting = 1'b1;
  int       m_frames  = 0;
  bit [3:0] m_o       = 4'd0;
  bit       m_valid   = 1'b0;
  bit       m_err     = 1'b0;

  demux_1x4_tdm #(.LOCK_CNT(LC)) dut (
    .clk(clk), .rst(rst), .Y(Y), .EN(EN), .SYNC(SYNC), .CLR(CLR),
    .O(O), .S(S), .VALID(VALID), .LOCK(LOCK), .ERR(ERR)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit en, input bit sy, input bit y, input bit clr);
    bit err_now;
    err_now = 1'b0;
    m_valid = 1'b0;
    if (r) begin
      frame_q.delete();
      m_hunting = 1'b1;
      m_frames  = 0;
      m_o       = 4'd0;
      m_err     = 1'b0;
      return;
    end
    if (en) begin
      if (m_hunting) begin
        if (sy) begin
          frame_q.delete();
          frame_q.push_back(y);
          m_hunting = 1'b0;
        end
      end else if (sy) begin
        if (frame_q.size() != 0) begin
          err_now  = 1'b1;
          m_frames = 0;
        end
        frame_q.delete();
        frame_q.push_back(y);
      end else if (frame_q.size() == 0) begin
        err_now   = 1'b1;
        m_frames  = 0;
        m_hunting = 1'b1;
      end else begin
        frame_q.push_back(y);
        if (frame_q.size() == 4) begin
          m_o     = {frame_q[3], frame_q[2], frame_q[1], frame_q[0]};
          m_valid = 1'b1;
          frame_q.delete();
          if (m_frames < 15) m_frames++;
        end
      end
    end
    m_err = err_now | (m_err & ~clr);
  endtask

  task automatic check_all();
    check("O",     O,           m_o);
    check("S",     {2'b00, S},  4'(frame_q.size() % 4));
    check("VALID", {3'b0, VALID}, {3'b0, m_valid});
    check("LOCK",  {3'b0, LOCK},  {3'b0, (m_frames >= LC)});
    check("ERR",   {3'b0, ERR},   {3'b0, m_err});
  endtask

  task automatic cycle(input bit r, input bit en, input bit sy, input bit y, input bit clr);
    @(negedge clk);
    rst = r; EN = en; SYNC = sy; Y = y; CLR = clr;
    @(posedge clk);
    model_step(r, en, sy, y, clr);
    #1;
    check_all();
  endtask

  // Frame bits are given as O would show them: bit k is the slot-k beat.
  task automatic send_frame(input bit [3:0] bits, input int gap);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, (k == 0), bits[k], 1'b0);
      if (k < 3)
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("rst_o", O, 4'd0);

    // Single frame 1101, then back-to-back 0110 reaches lock
    send_frame(4'b1101, 0);
    check("f1_o", O, 4'b1101);
    check("f1_valid", {3'b0, VALID}, 4'd1);
    check("f1_lock", {3'b0, LOCK}, 4'd0);
    send_frame(4'b0110, 0);
    check("f2_o", O, 4'b0110);
    check("f2_lock", {3'b0, LOCK}, 4'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Gapped frame: S advances only on strobed beats
    send_frame(4'b1101, 3);
    check("gap_o", O, 4'b1101);

    // Sync on slot 2 while locked
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("se_err", {3'b0, ERR}, 4'd1);
    check("se_lock", {3'b0, LOCK}, 4'd0);
    check("se_s", {2'b0, S}, 4'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("se_o", O, 4'b1001);

    // Clear, relock, then a missing sync with CLR in the same cycle
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_err", {3'b0, ERR}, 4'd0);
    send_frame(4'b0011, 0);
    check("relock", {3'b0, LOCK}, 4'd1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("ms_err", {3'b0, ERR}, 4'd1);
    check("ms_lock", {3'b0, LOCK}, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ms_hold", O, 4'b0011);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ms_clr", {3'b0, ERR}, 4'd0);

    // Reset mid-frame discards the partial frame
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mrst_o", O, 4'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("mrst_valid", {3'b0, VALID}, 4'd0);

    // Random beats, syncs mostly aligned so lock is reached regularly
    for (int i = 0; i < 400; i++) begin
      bit en, sy, y, clr, r;
      en  = ($urandom_range(0, 3) != 0);
      y   = 1'($urandom);
      clr = ($urandom_range(0, 7) == 0);
      r   = ($urandom_range(0, 99) == 0);
      if (frame_q.size() == 0) sy = ($urandom_range(0, 7) != 0);
      else                     sy = ($urandom_range(0, 15) == 0);
      cycle(r, en, sy, y, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
